// File: rtl/layer_compositor_pkg.sv
// Shared parameters, colour constants and fade FSM state type for the final pixel stage.
package layer_compositor_pkg;

  localparam int unsigned PIX_W           = 8;
  localparam int unsigned POS_W           = 12;
  localparam int unsigned PLAYABLE_AREA_H = 256;
  localparam int unsigned PLAYABLE_AREA_V = 240;
  localparam int unsigned LAT             = 2;

  // Colours packed as 24'hRRGGBB.
  localparam logic [23:0] BG_COLOR        = 24'h102030;
  localparam logic [23:0] BORDER_COLOR    = 24'h4080C0;

  typedef enum logic [1:0] {IDLE, FADE_OUT, HOLD, FADE_IN} fade_state_t;

  // Extract one BGR channel (0=B, 1=G, 2=R) from an RRGGBB constant.
  function automatic logic [PIX_W-1:0] rgb_chan(input logic [23:0] rgb, input int unsigned ch);
    return PIX_W'(rgb >> (8 * ch));
  endfunction

endpackage

// File: rtl/layer_compositor_fade.sv
// Frame-stepped fade controller: tracks the on-screen game state and the brightness level.
module fade_controller
  import layer_compositor_pkg::*;
#(
  parameter int unsigned FADE_DIV = 2,
  parameter int unsigned FADE_MAX = 8,
  parameter int unsigned LVL_W    = $clog2(FADE_MAX + 1)
) (
  input  logic             pixel_clk,
  input  logic             rst,
  input  logic             fsync,
  input  logic [1:0]       game_state,
  output logic [LVL_W-1:0] level,
  output logic [1:0]       shown_state,
  output logic             fading
);

  localparam logic [3:0]       CNT_LAST = 4'(FADE_DIV - 1);
  localparam logic [LVL_W-1:0] LVL_MAX  = LVL_W'(FADE_MAX);
  localparam logic [LVL_W-1:0] LVL_ONE  = LVL_W'(1);

  fade_state_t state;
  logic [3:0]  fsync_cnt;
  logic [1:0]  target;
  logic        step_c;
  logic        change_c;

  assign step_c   = (fsync_cnt == CNT_LAST);
  assign change_c = (game_state != shown_state);

  // Everything advances only on frame-start pulses; level is therefore constant within a frame.
  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      state       <= FADE_IN;
      fsync_cnt   <= 4'd0;
      level       <= '0;
      target      <= 2'd0;
      shown_state <= 2'd0;
      fading      <= 1'b1;
    end else if (fsync) begin
      fsync_cnt <= step_c ? 4'd0 : fsync_cnt + 4'd1;
      case (state)
        IDLE: begin
          level <= LVL_MAX;
          if (change_c) begin
            target    <= game_state;
            state     <= FADE_OUT;
            fsync_cnt <= 4'd0;
            fading    <= 1'b1;
          end
        end
        FADE_OUT: begin
          target <= game_state;
          if (step_c) begin
            if (level <= LVL_ONE) begin
              level     <= '0;
              state     <= HOLD;
              fsync_cnt <= 4'd0;
            end else begin
              level <= level - LVL_ONE;
            end
          end
        end
        HOLD: begin
          shown_state <= target;
          state       <= FADE_IN;
          fsync_cnt   <= 4'd0;
        end
        FADE_IN: begin
          if (change_c) begin
            target    <= game_state;
            state     <= FADE_OUT;
            fsync_cnt <= 4'd0;
          end else if (step_c) begin
            if (level >= LVL_MAX - LVL_ONE) begin
              level     <= LVL_MAX;
              state     <= IDLE;
              fsync_cnt <= 4'd0;
              fading    <= 1'b0;
            end else begin
              level <= level + LVL_ONE;
            end
          end
        end
        default: begin
          state  <= IDLE;
          fading <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/layer_compositor.sv
// Final pixel stage: priority layer mux with border masking, then brightness scaling by fade level.
module layer_compositor
  import layer_compositor_pkg::*;
#(
  parameter int unsigned FADE_DIV = 2,
  parameter int unsigned FADE_MAX = 8
) (
  input  logic                    pixel_clk,
  input  logic                    rst,
  input  logic                    fsync,
  input  logic                    de,
  input  logic signed [POS_W-1:0] hpos,
  input  logic signed [POS_W-1:0] vpos,
  input  logic [1:0]              game_state,
  input  logic [PIX_W-1:0]        star_pixel   [0:2],
  input  logic                    star_active,
  input  logic [PIX_W-1:0]        player_pixel [0:2],
  input  logic                    player_active,
  input  logic [PIX_W-1:0]        enemy_pixel  [0:2],
  input  logic                    enemy_active,
  input  logic [PIX_W-1:0]        bullet_pixel [0:2],
  input  logic                    bullet_active,
  output logic [PIX_W-1:0]        pixel_out    [0:2],
  output logic                    de_out,
  output logic [1:0]              shown_state,
  output logic                    fading
);

  localparam int unsigned LVL_W = $clog2(FADE_MAX + 1);
  localparam int unsigned SHIFT = $clog2(FADE_MAX);
  localparam int unsigned MUL_W = 12;

  localparam logic signed [POS_W-1:0] AREA_H = POS_W'(PLAYABLE_AREA_H);
  localparam logic signed [POS_W-1:0] AREA_V = POS_W'(PLAYABLE_AREA_V);
  localparam logic signed [POS_W-1:0] ZERO   = '0;

  logic [LVL_W-1:0] level;
  logic             in_area_c;
  logic [PIX_W-1:0] sel_c   [0:2];
  logic [MUL_W-1:0] prod_c  [0:2];
  logic [PIX_W-1:0] s1_pixel [0:2];
  logic             s1_de;

  fade_controller #(
    .FADE_DIV (FADE_DIV),
    .FADE_MAX (FADE_MAX),
    .LVL_W    (LVL_W)
  ) u_fade (
    .pixel_clk   (pixel_clk),
    .rst         (rst),
    .fsync       (fsync),
    .game_state  (game_state),
    .level       (level),
    .shown_state (shown_state),
    .fading      (fading)
  );

  assign in_area_c = (hpos >= ZERO) && (vpos >= ZERO) && (hpos < AREA_H) && (vpos < AREA_V);

  // Layer select; border wins over every layer outside the playable area.
  always_comb begin
    for (int unsigned i = 0; i < 3; i++) begin
      sel_c[i] = '0;
      if (!de)                sel_c[i] = '0;
      else if (!in_area_c)    sel_c[i] = rgb_chan(BORDER_COLOR, i);
      else if (bullet_active) sel_c[i] = bullet_pixel[i];
      else if (enemy_active)  sel_c[i] = enemy_pixel[i];
      else if (player_active) sel_c[i] = player_pixel[i];
      else if (star_active)   sel_c[i] = star_pixel[i];
      else                    sel_c[i] = rgb_chan(BG_COLOR, i);
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < 3; i++) begin
      prod_c[i] = MUL_W'(s1_pixel[i]) * MUL_W'(level);
    end
  end

  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < 3; i++) begin
        s1_pixel[i]  <= '0;
        pixel_out[i] <= '0;
      end
      s1_de  <= 1'b0;
      de_out <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < 3; i++) begin
        s1_pixel[i]  <= sel_c[i];
        pixel_out[i] <= PIX_W'(prod_c[i] >> SHIFT);
      end
      s1_de  <= de;
      de_out <= s1_de;
    end
  end

endmodule

// File: tb/tb_layer_compositor.sv
// Directed bench for layer_compositor: layer priority/border vectors plus fade sequences.
module tb_layer_compositor;

  logic              pixel_clk = 1'b0;
  logic              rst;
  logic              fsync;
  logic              de;
  logic signed [11:0] hpos;
  logic signed [11:0] vpos;
  logic [1:0]        game_state;
  logic [7:0]        star_pixel   [0:2];
  logic              star_active;
  logic [7:0]        player_pixel [0:2];
  logic              player_active;
  logic [7:0]        enemy_pixel  [0:2];
  logic              enemy_active;
  logic [7:0]        bullet_pixel [0:2];
  logic              bullet_active;
  logic [7:0]        pixel_out    [0:2];
  logic              de_out;
  logic [1:0]        shown_state;
  logic              fading;

  int n_total = 0;
  int n_pass  = 0;

  localparam logic [23:0] EXP_BG     = 24'h102030;
  localparam logic [23:0] EXP_BORDER = 24'h4080C0;
  localparam logic [23:0] C_STAR     = 24'h030201;
  localparam logic [23:0] C_PLAYER   = 24'h060504;
  localparam logic [23:0] C_ENEMY    = 24'h090807;
  localparam logic [23:0] C_BULLET   = 24'h0C0B0A;

  layer_compositor #(.FADE_DIV(2), .FADE_MAX(8)) dut (
    .pixel_clk     (pixel_clk),
    .rst           (rst),
    .fsync         (fsync),
    .de            (de),
    .hpos          (hpos),
    .vpos          (vpos),
    .game_state    (game_state),
    .star_pixel    (star_pixel),
    .star_active   (star_active),
    .player_pixel  (player_pixel),
    .player_active (player_active),
    .enemy_pixel   (enemy_pixel),
    .enemy_active  (enemy_active),
    .bullet_pixel  (bullet_pixel),
    .bullet_active (bullet_active),
    .pixel_out     (pixel_out),
    .de_out        (de_out),
    .shown_state   (shown_state),
    .fading        (fading)
  );

  always #5 pixel_clk = ~pixel_clk;

  typedef struct {
    logic        de;
    int          hpos;
    int          vpos;
    logic [3:0]  act;     // {bullet, enemy, player, star}
    logic [23:0] exp_rgb;
    logic        exp_de;
  } vec_t;

  vec_t vecs [12];

  function automatic logic [23:0] got_rgb();
    return {pixel_out[2], pixel_out[1], pixel_out[0]};
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
  endtask

  task automatic set_pix(output logic [7:0] p [0:2], input logic [23:0] rgb);
    p[0] = rgb[7:0];
    p[1] = rgb[15:8];
    p[2] = rgb[23:16];
  endtask

  task automatic white_star();
    de = 1'b1; hpos = 12'sd10; vpos = 12'sd10;
    set_pix(star_pixel, 24'hFFFFFF);
    star_active = 1'b1; player_active = 1'b0; enemy_active = 1'b0; bullet_active = 1'b0;
  endtask

  // One frame pulse, then check brightness of the white star, shown_state and fading.
  task automatic fs(input int lvl, input logic [1:0] sh, input logic fd, input string tag);
    logic [7:0] ch;
    ch = 8'((255 * lvl) >> 3);
    fsync = 1'b1;
    @(posedge pixel_clk); @(negedge pixel_clk);
    fsync = 1'b0;
    repeat (3) @(posedge pixel_clk);
    @(negedge pixel_clk);
    chk($sformatf("%s pixel lvl%0d", tag, lvl), 32'(got_rgb()), 32'({ch, ch, ch}));
    chk($sformatf("%s shown", tag), 32'(shown_state), 32'(sh));
    chk($sformatf("%s fading", tag), 32'(fading), 32'(fd));
  endtask

  initial begin
    vecs[0]  = '{1'b1, 100,  50, 4'b1011, C_BULLET,   1'b1};
    vecs[1]  = '{1'b1, 100,  50, 4'b0001, C_STAR,     1'b1};
    vecs[2]  = '{1'b1, 100,  50, 4'b0000, EXP_BG,     1'b1};
    vecs[3]  = '{1'b1,  -1,  10, 4'b1000, EXP_BORDER, 1'b1};
    vecs[4]  = '{1'b1, 256,  10, 4'b1000, EXP_BORDER, 1'b1};
    vecs[5]  = '{1'b1, 255,  10, 4'b1000, C_BULLET,   1'b1};
    vecs[6]  = '{1'b1,  10, 240, 4'b0100, EXP_BORDER, 1'b1};
    vecs[7]  = '{1'b1,  10,  -1, 4'b0100, EXP_BORDER, 1'b1};
    vecs[8]  = '{1'b0, 100,  50, 4'b1111, 24'h000000, 1'b0};
    vecs[9]  = '{1'b1, 100,  50, 4'b0110, C_ENEMY,    1'b1};
    vecs[10] = '{1'b1, 100,  50, 4'b0011, C_PLAYER,   1'b1};
    vecs[11] = '{1'b1,   0,   0, 4'b0001, C_STAR,     1'b1};

    rst = 1'b1; fsync = 1'b0; game_state = 2'd0;
    white_star();
    set_pix(player_pixel, C_PLAYER);
    set_pix(enemy_pixel, C_ENEMY);
    set_pix(bullet_pixel, C_BULLET);
    repeat (3) @(posedge pixel_clk);
    @(negedge pixel_clk);
    chk("reset pixel", 32'(got_rgb()), 32'h0);
    chk("reset de_out", 32'(de_out), 32'h0);
    chk("reset shown", 32'(shown_state), 32'h0);
    chk("reset fading", 32'(fading), 32'h1);
    rst = 1'b0;
    repeat (4) @(posedge pixel_clk);
    @(negedge pixel_clk);
    chk("powerup black", 32'(got_rgb()), 32'h0);
    chk("powerup de_out", 32'(de_out), 32'h1);

    // Power-up fade-in from black.
    for (int i = 1; i <= 16; i++) fs(i / 2, 2'd0, 1'(i < 16), "pwr");

    // Layer priority and border vectors, streamed to check the exact 2-cycle latency.
    set_pix(star_pixel, C_STAR);
    for (int k = 0; k < 14; k++) begin
      if (k >= 2) begin
        chk($sformatf("vec%0d rgb", k - 2), 32'(got_rgb()), 32'(vecs[k-2].exp_rgb));
        chk($sformatf("vec%0d de_out", k - 2), 32'(de_out), 32'(vecs[k-2].exp_de));
      end
      if (k < 12) begin
        de = vecs[k].de;
        hpos = 12'(vecs[k].hpos);
        vpos = 12'(vecs[k].vpos);
        {bullet_active, enemy_active, player_active, star_active} = vecs[k].act;
      end else begin
        de = 1'b0;
      end
      @(posedge pixel_clk); @(negedge pixel_clk);
    end

    // State change 0->2 is ignored until the next frame pulse.
    white_star();
    game_state = 2'd2;
    repeat (5) @(posedge pixel_clk);
    @(negedge pixel_clk);
    chk("pre-fsync shown", 32'(shown_state), 32'h0);
    chk("pre-fsync fading", 32'(fading), 32'h0);
    chk("pre-fsync pixel", 32'(got_rgb()), 32'hFFFFFF);
    fs(8, 2'd0, 1'b1, "out2 entry");
    for (int j = 1; j <= 16; j++) fs(8 - j / 2, 2'd0, 1'b1, "out2");
    fs(0, 2'd2, 1'b1, "hold2");
    for (int j = 1; j <= 16; j++) fs(j / 2, 2'd2, 1'(j < 16), "in2");

    // Re-target during fade-in at level 3: fade out from 3, no jump.
    game_state = 2'd3;
    fs(8, 2'd2, 1'b1, "out3 entry");
    for (int j = 1; j <= 16; j++) fs(8 - j / 2, 2'd2, 1'b1, "out3");
    fs(0, 2'd3, 1'b1, "hold3");
    for (int j = 1; j <= 6; j++) fs(j / 2, 2'd3, 1'b1, "in3");
    game_state = 2'd1;
    fs(3, 2'd3, 1'b1, "retarget");
    for (int j = 1; j <= 6; j++) fs(3 - j / 2, 2'd3, 1'b1, "out1");
    fs(0, 2'd1, 1'b1, "hold1");
    for (int j = 1; j <= 16; j++) fs(j / 2, 2'd1, 1'(j < 16), "in1");

    // Reset mid fade-out at level 5 clears everything without a clock edge.
    game_state = 2'd0;
    fs(8, 2'd1, 1'b1, "out0 entry");
    for (int j = 1; j <= 6; j++) fs(8 - j / 2, 2'd1, 1'b1, "out0");
    #2 rst = 1'b1;
    #1;
    chk("async rst pixel", 32'(got_rgb()), 32'h0);
    chk("async rst de_out", 32'(de_out), 32'h0);
    chk("async rst shown", 32'(shown_state), 32'h0);
    chk("async rst fading", 32'(fading), 32'h1);
    @(negedge pixel_clk);
    rst = 1'b0;
    repeat (3) @(posedge pixel_clk);
    @(negedge pixel_clk);
    chk("post rst black", 32'(got_rgb()), 32'h0);
    chk("post rst de_out", 32'(de_out), 32'h1);
    fs(0, 2'd0, 1'b1, "post rst");
    fs(1, 2'd0, 1'b1, "post rst");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
